direction_queue: RTL and testbench
==================================

// Module: direction_queue
// PURPOSE
//  Parametrised successor to the snake direction latch. Synchronises and debounces
//  the w/a/s/d buttons and turns each new press into a direction event. Queues up
//  to DEPTH valid turns, so fast key sequences between game steps are not lost.
//  Sits between the board buttons and the snake movement logic; one queued turn
//  is applied per game tick.
// PARAMETERS
//  DEPTH       4        turn-queue entries (>=2, power of two)
//  DEB_CYCLES  16       clock cycles a synchronised key must be stable to change state (>=1)
//  INIT_DIR    4'b0001  direction after reset (one-hot, up)
// PORTS
//  clock       in   1   system clock, all logic on posedge
//  reset_n     in   1   synchronous reset, active-low
//  w,a,s,d     in   1   raw buttons, active-high, asynchronous to clock
//  tick        in   1   game-step strobe, 1-cycle pulse; pops one queued turn
//  direcao     out  4   current direction, one-hot: 0001 up, 0010 left, 0100 down, 1000 right
//  count       out  $clog2(DEPTH)+1  queued turns, 0..DEPTH
//  full        out  1   count==DEPTH
//  dropped     out  1   1-cycle pulse: valid turn lost because queue full
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): direcao=INIT_DIR, count=0, full=0, dropped=0,
//    sync flops, debounce counters and debounced key states cleared to 0.
//  - Per key: 2-flop synchroniser -> debouncer. Debounced state flips only after the
//    synchronised value differs from it for DEB_CYCLES consecutive cycles; any bounce
//    restarts the counter. A 0->1 transition of a debounced state is a press event.
//    A key held through reset gives one event after sync+DEB_CYCLES.
//  - Simultaneous press events in one cycle: only the highest priority is used,
//    w > a > s > d; the rest are discarded (no pulse).
//  - Reference direction REF = queue tail if count>0, else direcao.
//    Event rejected silently if it equals REF or is opposite of REF (up/down, left/right).
//  - Accepted event: pushed at tail if count<DEPTH (or count==DEPTH with tick same
//    cycle); otherwise dropped=1 for one cycle, queue unchanged.
//  - tick with count>0: head popped into direcao at that posedge; count-1.
//    tick with count==0: direcao holds. direcao changes only on tick.
//  - Same-cycle push and pop: both happen, count unchanged; REF is the pre-pop tail.
//  - Latency: raw edge -> event = 2 + DEB_CYCLES cycles; event -> queued next posedge;
//    queued -> direcao at first tick after.
//  - Pointers wrap modulo DEPTH. count never exceeds DEPTH, never underflows.
//  - direcao is always one-hot; queue holds only one-hot values.
// CONFIGURATION
//  - DIRQ_DEBOUNCE_EN defined: debouncer as above.
//  - DIRQ_DEBOUNCE_EN undefined: debouncer removed; debounced state = synchronised
//    value, event latency 2 cycles; DEB_CYCLES ignored. All other behaviour identical.
// TESTING
//  1 reset_n=0 one cycle, then idle -> direcao=0001, count=0, full=0, dropped=0.
//  2 press d clean for DEB_CYCLES+5, then tick -> count 1 after 2+DEB_CYCLES+1 cycles;
//    on tick direcao=1000, count=0.
//  3 from up: press s (opposite) -> rejected, count=0; press w (same) -> rejected.
//  4 from up, no tick: a, s, d, w, a presses -> queue 0010,0100,1000,0001 full=1;
//    5th valid turn (a from REF 0001) -> dropped pulse; 4 ticks give 0010,0100,1000,0001.
//  5 full queue, valid event and tick same cycle -> push accepted, count stays 4, no drop.
//  6 bounce w toggling every 3 cycles (< DEB_CYCLES) for 100 cycles -> no event;
//    w and d rise in same cycle -> only w considered; reset mid-queue -> all cleared.

Source files
------------

// File: rtl/direction_queue.sv
// Key synchroniser/debouncer feeding a DEPTH-entry turn queue for snake steering.
// Optional debouncer enabled by defining DIRQ_DEBOUNCE_EN.
module direction_queue #(
    parameter int          DEPTH      = 4,
    parameter int          DEB_CYCLES = 16,
    parameter logic [3:0]  INIT_DIR   = 4'b0001
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     w,
    input  logic                     a,
    input  logic                     s,
    input  logic                     d,
    input  logic                     tick,
    output logic [3:0]               direcao,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     dropped
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [3:0]      w_raw;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      w_deb;
    logic [3:0]      r_deb_q;
    logic [3:0]      w_press;
    logic [3:0]      w_evt;
    logic [3:0]      w_ref;
    logic [3:0]      w_opp;
    logic            w_valid;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [AW-1:0]   w_tail;

    logic [3:0]      r_q [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CNTW-1:0] r_count;
    logic [3:0]      r_dir;
    logic            r_dropped;

    // Bit i of every key vector is the direction bit that key requests
    assign w_raw = {d, s, a, w};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DIRQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic [DW-1:0] r_dcnt [4];
    logic [3:0]    r_deb;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_deb <= '0;
            for (int i = 0; i < 4; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_deb[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_deb = r_deb;
`else
    assign w_deb = r_sync2;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_deb_q <= '0;
        end else begin
            r_deb_q <= w_deb;
        end
    end

    assign w_press = w_deb & ~r_deb_q;

    // Fixed priority w > a > s > d; losers are simply discarded
    always_comb begin
        w_evt = 4'b0000;
        if (w_press[0]) begin
            w_evt = 4'b0001;
        end else if (w_press[1]) begin
            w_evt = 4'b0010;
        end else if (w_press[2]) begin
            w_evt = 4'b0100;
        end else if (w_press[3]) begin
            w_evt = 4'b1000;
        end
    end

    assign w_tail  = r_wp - 1'b1;
    assign w_ref   = (r_count != '0) ? r_q[w_tail] : r_dir;
    assign w_opp   = {w_ref[1:0], w_ref[3:2]};
    assign w_valid = (w_evt != 4'b0000) && (w_evt != w_ref) && (w_evt != w_opp);
    assign w_full  = (r_count == CNTW'(DEPTH));
    assign w_pop   = tick && (r_count != '0);
    assign w_push  = w_valid && (!w_full || tick);
    assign w_drop  = w_valid && w_full && !tick;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q[r_wp] <= w_evt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_dir     <= INIT_DIR;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_drop;
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp  <= r_rp + 1'b1;
                r_dir <= r_q[r_rp];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign direcao = r_dir;
    assign count   = r_count;
    assign full    = w_full;
    assign dropped = r_dropped;

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue: reset, turn filtering, queue fill/drop,
// push-with-pop, bounce rejection and key priority.
module tb_direction_queue;

    localparam int DEPTH = 4;
    localparam int DEB   = 16;
`ifdef DIRQ_DEBOUNCE_EN
    localparam int L = 2 + DEB;
`else
    localparam int L = 2;
`endif

    logic       clk;
    logic       reset_n;
    logic [3:0] keys;
    logic       tick;
    logic [3:0] direcao;
    logic [2:0] count;
    logic       full;
    logic       dropped;

    int n_vec;
    int n_err;

    direction_queue #(
        .DEPTH(DEPTH),
        .DEB_CYCLES(DEB),
        .INIT_DIR(4'b0001)
    ) dut (
        .clock(clk),
        .reset_n(reset_n),
        .w(keys[0]),
        .a(keys[1]),
        .s(keys[2]),
        .d(keys[3]),
        .tick(tick),
        .direcao(direcao),
        .count(count),
        .full(full),
        .dropped(dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        keys = '0;
        tick = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic press(input int k);
        @(negedge clk);
        keys[k] = 1'b1;
        repeat (L + 2) @(negedge clk);
        keys[k] = 1'b0;
        repeat (L + 2) @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(negedge clk);
        chk("reset_dir", direcao, 4'b0001);
        chk("reset_count", {1'b0, count}, 4'd0);
        chk("reset_full", {3'b0, full}, 4'd0);
        chk("reset_dropped", {3'b0, dropped}, 4'd0);
    endtask

    task automatic test_single_turn();
        do_reset();
        @(negedge clk);
        keys[3] = 1'b1;
        repeat (L) @(negedge clk);
        chk("latency_before", {1'b0, count}, 4'd0);
        @(negedge clk);
        chk("latency_queued", {1'b0, count}, 4'd1);
        repeat (4) @(negedge clk);
        keys[3] = 1'b0;
        repeat (L + 2) @(negedge clk);
        chk("held_once", {1'b0, count}, 4'd1);
        chk("dir_before_tick", direcao, 4'b0001);
        do_tick();
        chk("tick_dir", direcao, 4'b1000);
        chk("tick_count", {1'b0, count}, 4'd0);
    endtask

    task automatic test_reject();
        do_reset();
        press(2);
        chk("reject_opposite", {1'b0, count}, 4'd0);
        press(0);
        chk("reject_same", {1'b0, count}, 4'd0);
        press(1);
        chk("accept_left", {1'b0, count}, 4'd1);
        do_tick();
        chk("left_applied", direcao, 4'b0010);
    endtask

    task automatic test_fill_drop();
        int pulses;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        exp_seq[3] = 4'b0001;
        do_reset();
        press(1);
        press(2);
        press(3);
        press(0);
        chk("fill_count", {1'b0, count}, 4'd4);
        chk("fill_full", {3'b0, full}, 4'd1);
        pulses = 0;
        @(negedge clk);
        keys[1] = 1'b1;
        repeat (L + 3) begin
            @(negedge clk);
            if (dropped === 1'b1) pulses++;
        end
        keys[1] = 1'b0;
        repeat (L + 2) @(negedge clk);
        chk("drop_pulses", 4'(pulses), 4'd1);
        chk("drop_count", {1'b0, count}, 4'd4);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            chk("pop_dir", direcao, exp_seq[i]);
            chk("pop_count", {1'b0, count}, 4'(3 - i));
        end
        chk("empty_full", {3'b0, full}, 4'd0);
        do_tick();
        chk("empty_tick_hold", direcao, 4'b0001);
        chk("no_underflow", {1'b0, count}, 4'd0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0100;
        exp_seq[1] = 4'b1000;
        exp_seq[2] = 4'b0001;
        exp_seq[3] = 4'b0010;
        press(1);
        press(2);
        press(3);
        press(0);
        chk("b2b_full", {3'b0, full}, 4'd1);
        @(negedge clk);
        keys[1] = 1'b1;
        repeat (L) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("b2b_count", {1'b0, count}, 4'd4);
        chk("b2b_dropped", {3'b0, dropped}, 4'd0);
        chk("b2b_dir", direcao, 4'b0010);
        repeat (3) @(negedge clk);
        keys[1] = 1'b0;
        repeat (L + 2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            chk("b2b_pop", direcao, exp_seq[i]);
        end
        chk("b2b_empty", {1'b0, count}, 4'd0);
    endtask

    task automatic test_bounce_priority();
        do_reset();
`ifdef DIRQ_DEBOUNCE_EN
        keys[1] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 3 == 2) keys[1] = ~keys[1];
        end
        keys[1] = 1'b0;
        repeat (L + 4) @(negedge clk);
        chk("bounce_none", {1'b0, count}, 4'd0);
`endif
        @(negedge clk);
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        repeat (L + 3) @(negedge clk);
        keys = '0;
        repeat (L + 2) @(negedge clk);
        chk("prio_w_wins", {1'b0, count}, 4'd0);
        press(1);
        press(2);
        chk("mid_count", {1'b0, count}, 4'd2);
        do_tick();
        chk("mid_dir", direcao, 4'b0010);
        do_reset();
        @(negedge clk);
        chk("rst_dir", direcao, 4'b0001);
        chk("rst_count", {1'b0, count}, 4'd0);
        chk("rst_full", {3'b0, full}, 4'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b1;
        keys    = '0;
        tick    = 1'b0;
        test_reset();
        test_single_turn();
        test_reject();
        test_fill_drop();
        test_back_to_back();
        test_bounce_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
